rd_interface_core: RTL and testbench
====================================

// Module: rd_interface_core
// PURPOSE
//  Radio-detector (RD) readout front end. Deserialises a 2-lane serial stream clocked by the RD
//  into 32-bit words and writes them to one of four memory buffers via a simple write port.
//  A trigger arms capture. An enable strobe gates the transfer. AXI-side control/status words
//  connect it to the PS. Sits between the RD serial link and the trace-buffer memory.
// PARAMETERS
//  BASE_ADDR      32'h0000_0000  byte address of buffer 0
//  WORDS_PER_BUF  1024           32-bit words per buffer; a buffer spans WORDS_PER_BUF*4 bytes
// PORTS
//  SERIAL_CLK_IN        in   1   sole clock, rising edge; supplied by the RD
//  RESET_N_IN           in   1   synchronous, active-low reset
//  SERIAL_DATA0_IN      in   1   serial lane 0 (even bit of each pair)
//  SERIAL_DATA1_IN      in   1   serial lane 1 (odd bit of each pair)
//  ENABLE_XFR_IN        in   1   high while RD streams valid data
//  BUF_NUM              in   2   target buffer; latched at arm time
//  TRIG_IN              in   1   trigger; rising edge arms capture
//  AXI_CONTROL          in   32  control word; sampled when AXI_CONTROL_WRITTEN=1
//  AXI_CONTROL_WRITTEN  in   1   one-cycle strobe: AXI_CONTROL is valid
//  STATUS               out  32  status word (see BEHAVIOUR)
//  DATA_ADDR            out  32  byte address of the current write
//  DATA_TO_MEM          out  32  write data
//  ENABLE_MEM_WRT       out  1   one-cycle write strobe
//  DEBUG1               out  1   copy of ENABLE_MEM_WRT
//  DEBUG2               out  1   high in state XFER
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; ctrl ENABLE=1; counters, flags and shift register cleared.
//  States:
//   IDLE  -> ARMED on TRIG_IN rising edge with ENABLE=1; latch BUF_NUM; word_idx=0
//   ARMED -> XFER on the first edge ENABLE_XFR_IN=1; that edge samples the first pair
//   XFER  -> DONE when ENABLE_XFR_IN=0 or word_idx reaches WORDS_PER_BUF
//   DONE  -> ARMED on a new TRIG_IN rising edge (ENABLE=1)
//  Shift per XFER edge: sr <= {sr[29:0], SERIAL_DATA1_IN, SERIAL_DATA0_IN}. First pair ends up
//   in bits [31:30].
//  After the 16th pair, the next cycle drives ENABLE_MEM_WRT=1 for one cycle, with
//   DATA_TO_MEM=sr and DATA_ADDR=BASE_ADDR+latched_buf*WORDS_PER_BUF*4+word_idx*4.
//   word_idx then increments.
//  ENABLE_XFR_IN falling mid-word: the partial word is discarded and never written.
//  Buffer full: at WORDS_PER_BUF words, go to DONE; further ENABLE_XFR_IN is ignored until re-armed.
//  TRIG_IN rising in ARMED or XFER: ignored; sets OVERFLOW.
//  AXI_CONTROL on strobe: bit0 CLEAR (self-clearing; clears DONE/OVERFLOW, state -> IDLE,
//   aborts XFER with no write); bit1 ENABLE (level, reset 1). CLEAR wins over a same-cycle TRIG.
//  STATUS: [0] busy (XFER), [1] done, [2] armed, [3] overflow, [5:4] latched buffer,
//   [6] ctrl ENABLE, [26:16] word_idx, others 0.
// CONFIGURATION
//  RD_TEST_PATTERN_EN defined: AXI_CONTROL bit2 (TEST) is implemented. When TEST=1, the XFER write
//   data is a 32-bit counter starting at 0 per arm instead of sr. Timing and addresses are unchanged.
//  RD_TEST_PATTERN_EN undefined: bit2 is ignored; STATUS[7]=0.
//  With the macro defined, STATUS[7] reflects TEST.
// STRUCTURE
//  Package rd_interface_pkg: state encoding, STATUS and AXI_CONTROL bit indices, WORDS_PER_BUF default.
//  Sub-module rd_deser_2to32: 2-lane shift register plus 4-bit pair counter and word_valid pulse.
// TESTING
//  1. Reset, pulse TRIG_IN, DATA1=1/DATA0=0 held, ENABLE_XFR_IN high 32 cycles
//     -> two writes of 0xAAAAAAAA at addr 0x0 and 0x4.
//  2. BUF_NUM=2 at trigger, both lanes 1, one word -> DATA_TO_MEM=0xFFFFFFFF, DATA_ADDR=0x2000.
//  3. ENABLE_XFR_IN dropped after 10 pairs -> no write; STATUS[1]=1, STATUS[26:16]=0.
//  4. Stream 1025 words -> exactly 1024 writes, last at 0xFFC; STATUS[1]=1.
//  5. TRIG_IN during XFER -> STATUS[3]=1. Then AXI_CONTROL=1 with strobe -> STATUS=0x40, state IDLE.
//  6. Reset asserted mid-XFER -> ENABLE_MEM_WRT and STATUS 0 on the next edge; ctrl ENABLE back to 1.

Source files
------------

// File: rtl/rd_interface_pkg.sv
// Shared definitions for the radio-detector readout front end: FSM encoding,
// STATUS / AXI_CONTROL bit positions, buffer sizing and the write-address helper.
package rd_interface_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_XFER  = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_e;

    localparam int unsigned WORDS_PER_BUF_DEF = 1024;
    localparam int unsigned IDX_W             = 11;

    localparam int STAT_BUSY   = 0;
    localparam int STAT_DONE   = 1;
    localparam int STAT_ARMED  = 2;
    localparam int STAT_OVF    = 3;
    localparam int STAT_BUF_LO = 4;
    localparam int STAT_EN     = 6;
    localparam int STAT_TEST   = 7;
    localparam int STAT_IDX_LO = 16;

    localparam int CTRL_CLEAR  = 0;
    localparam int CTRL_ENABLE = 1;
    localparam int CTRL_TEST   = 2;

    function automatic logic [31:0] rd_word_addr(input logic [31:0]      base,
                                                 input logic [1:0]       buf_sel,
                                                 input logic [IDX_W-1:0] idx,
                                                 input logic [31:0]      words);
        return base + ({30'd0, buf_sel} * (words * 32'd4)) + {19'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/rd_interface_core_if.sv
// Bus bundle between the RD link / PS control side (master) and the readout core (slave).
interface rd_interface_core_if;
    logic        SERIAL_DATA0_IN;
    logic        SERIAL_DATA1_IN;
    logic        ENABLE_XFR_IN;
    logic [1:0]  BUF_NUM;
    logic        TRIG_IN;
    logic [31:0] AXI_CONTROL;
    logic        AXI_CONTROL_WRITTEN;
    logic [31:0] STATUS;
    logic [31:0] DATA_ADDR;
    logic [31:0] DATA_TO_MEM;
    logic        ENABLE_MEM_WRT;
    logic        DEBUG1;
    logic        DEBUG2;

    modport master (
        output SERIAL_DATA0_IN, SERIAL_DATA1_IN, ENABLE_XFR_IN, BUF_NUM, TRIG_IN,
               AXI_CONTROL, AXI_CONTROL_WRITTEN,
        input  STATUS, DATA_ADDR, DATA_TO_MEM, ENABLE_MEM_WRT, DEBUG1, DEBUG2
    );

    modport slave (
        input  SERIAL_DATA0_IN, SERIAL_DATA1_IN, ENABLE_XFR_IN, BUF_NUM, TRIG_IN,
               AXI_CONTROL, AXI_CONTROL_WRITTEN,
        output STATUS, DATA_ADDR, DATA_TO_MEM, ENABLE_MEM_WRT, DEBUG1, DEBUG2
    );
endinterface

// File: rtl/rd_deser_2to32.sv
// Two-lane deserialiser: 16 bit-pairs form one 32-bit word, first pair in bits [31:30].
// word/word_valid describe the word completed by the pair sampled on this edge.
module rd_deser_2to32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        shift,
    input  logic        d0,
    input  logic        d1,
    output logic [31:0] word,
    output logic        word_valid
);
    logic [31:0] sr_q, sr_d;
    logic [3:0]  cnt_q, cnt_d;

    // Next shift-register and pair-count values; clearing drops any partial word.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (clr) begin
            sr_d  = 32'd0;
            cnt_d = 4'd0;
        end else if (shift) begin
            sr_d  = {sr_q[29:0], d1, d0};
            cnt_d = cnt_q + 4'd1;
        end else begin
            sr_d  = sr_q;
            cnt_d = cnt_q;
        end
        word       = {sr_q[29:0], d1, d0};
        word_valid = shift & ~clr & (cnt_q == 4'd15);
    end

    // Shift-register and pair-counter state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q  <= 32'd0;
            cnt_q <= 4'd0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/rd_interface_core.sv
// Radio-detector readout core: arm on trigger, deserialise the 2-lane stream and emit
// one registered memory write per 32-bit word. Optional feature macro: RD_TEST_PATTERN_EN.
module rd_interface_core
    import rd_interface_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter int unsigned WORDS_PER_BUF = WORDS_PER_BUF_DEF
) (
    input  logic                SERIAL_CLK_IN,
    input  logic                RESET_N_IN,
    rd_interface_core_if.slave  bus
);
    rd_state_e        state_q, state_d;
    logic             trig_prev_q;
    logic [1:0]       buf_q, buf_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             ovf_q, ovf_d;
    logic             en_q, en_d;
    logic             wr_q, wr_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic [31:0]      status_q, status_d;
    logic             dbg2_q, dbg2_d;
    logic             trig_rise_s, clr_s, shift_s, arm_s, word_valid_s;
    logic [31:0]      word_s;
    logic             ctrl_unused_s;
`ifdef RD_TEST_PATTERN_EN
    logic             test_q, test_d;
    logic [31:0]      pat_q, pat_d;
`endif

    rd_deser_2to32 u_deser (
        .clk        (SERIAL_CLK_IN),
        .rst_n      (RESET_N_IN),
        .clr        (~shift_s),
        .shift      (shift_s),
        .d0         (bus.SERIAL_DATA0_IN),
        .d1         (bus.SERIAL_DATA1_IN),
        .word       (word_s),
        .word_valid (word_valid_s)
    );

    // Control FSM, write generation and STATUS composition.
    always_comb begin
        trig_rise_s = bus.TRIG_IN & ~trig_prev_q;
        clr_s       = bus.AXI_CONTROL_WRITTEN & bus.AXI_CONTROL[CTRL_CLEAR];
        shift_s     = ~clr_s & bus.ENABLE_XFR_IN & ((state_q == ST_ARMED) || (state_q == ST_XFER));
        state_d = state_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        ovf_d   = ovf_q;
        en_d    = en_q;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        arm_s   = 1'b0;
        // A CLEAR write is a command only; ENABLE keeps its value across it.
        if (bus.AXI_CONTROL_WRITTEN && !clr_s) begin
            en_d = bus.AXI_CONTROL[CTRL_ENABLE];
        end else begin
            en_d = en_q;
        end
        if (clr_s) begin
            state_d = ST_IDLE;
            ovf_d   = 1'b0;
            buf_d   = 2'd0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (trig_rise_s && en_q) begin
                        state_d = ST_ARMED;
                        buf_d   = bus.BUF_NUM;
                        idx_d   = '0;
                        arm_s   = 1'b1;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_ARMED: begin
                    ovf_d   = ovf_q | trig_rise_s;
                    state_d = bus.ENABLE_XFR_IN ? ST_XFER : ST_ARMED;
                end
                ST_XFER: begin
                    ovf_d = ovf_q | trig_rise_s;
                    if (!bus.ENABLE_XFR_IN) begin
                        state_d = ST_DONE;
                    end else if (word_valid_s) begin
                        wr_d   = 1'b1;
                        addr_d = rd_word_addr(BASE_ADDR, buf_q, idx_q, 32'(WORDS_PER_BUF));
                        data_d = word_s;
                        idx_d  = idx_q + 11'd1;
                        state_d = ((32'(idx_q) + 32'd1) == 32'(WORDS_PER_BUF)) ? ST_DONE : ST_XFER;
                    end else begin
                        state_d = ST_XFER;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        status_d = 32'd0;
        status_d[STAT_BUSY]            = (state_d == ST_XFER);
        status_d[STAT_DONE]            = (state_d == ST_DONE);
        status_d[STAT_ARMED]           = (state_d == ST_ARMED);
        status_d[STAT_OVF]             = ovf_d;
        status_d[STAT_BUF_LO +: 2]     = buf_d;
        status_d[STAT_EN]              = en_d;
        status_d[STAT_IDX_LO +: IDX_W] = idx_d;
        dbg2_d = (state_d == ST_XFER);
`ifdef RD_TEST_PATTERN_EN
        test_d = (bus.AXI_CONTROL_WRITTEN && !clr_s) ? bus.AXI_CONTROL[CTRL_TEST] : test_q;
        if (clr_s || arm_s) begin
            pat_d = 32'd0;
        end else if (wr_d) begin
            pat_d = pat_q + 32'd1;
        end else begin
            pat_d = pat_q;
        end
        data_d = (wr_d && test_q) ? pat_q : data_d;
        status_d[STAT_TEST] = test_d;
        ctrl_unused_s = ^bus.AXI_CONTROL[31:3];
`else
        ctrl_unused_s = ^bus.AXI_CONTROL[31:2] ^ arm_s;
`endif
    end

    // State and registered outputs.
    always_ff @(posedge SERIAL_CLK_IN) begin
        if (!RESET_N_IN) begin
            state_q     <= ST_IDLE;
            trig_prev_q <= 1'b0;
            buf_q       <= 2'd0;
            idx_q       <= '0;
            ovf_q       <= 1'b0;
            en_q        <= 1'b1;
            wr_q        <= 1'b0;
            addr_q      <= 32'd0;
            data_q      <= 32'd0;
            status_q    <= 32'd0;
            dbg2_q      <= 1'b0;
`ifdef RD_TEST_PATTERN_EN
            test_q      <= 1'b0;
            pat_q       <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            trig_prev_q <= bus.TRIG_IN;
            buf_q       <= buf_d;
            idx_q       <= idx_d;
            ovf_q       <= ovf_d;
            en_q        <= en_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            status_q    <= status_d;
            dbg2_q      <= dbg2_d;
`ifdef RD_TEST_PATTERN_EN
            test_q      <= test_d;
            pat_q       <= pat_d;
`endif
        end
    end

    assign bus.STATUS         = status_q;
    assign bus.DATA_ADDR      = addr_q;
    assign bus.DATA_TO_MEM    = data_q;
    assign bus.ENABLE_MEM_WRT = wr_q;
    assign bus.DEBUG1         = wr_q;
    assign bus.DEBUG2         = dbg2_q;
endmodule

// File: tb/tb_rd_interface_core.sv
// Scoreboard bench for rd_interface_core: expected writes are derived from the streamed bit
// pairs and queued; a negedge monitor pops and compares every memory write strobe.
module tb_rd_interface_core;
    localparam int WPB = 1024;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rd_interface_core_if bus();

    rd_interface_core #(.BASE_ADDR(32'h0000_0000), .WORDS_PER_BUF(WPB)) dut (
        .SERIAL_CLK_IN (clk),
        .RESET_N_IN    (rst_n),
        .bus           (bus)
    );

    int  n_cmp = 0;
    int  n_bad = 0;
    int  n_pushed = 0;
    int  n_seen = 0;
    wr_t exp_q[$];
    wr_t mon_e;
    int  m_buf = 0, m_idx = 0, m_done = 0, m_armed = 0, m_ovf = 0, m_en = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_status(input int busy);
        return 32'(busy + 2 * m_done + 4 * m_armed + 8 * m_ovf + 16 * m_buf + 64 * m_en + 65536 * m_idx);
    endfunction

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && bus.ENABLE_MEM_WRT === 1'b1) begin
            n_seen++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, none expected",
                         bus.DATA_ADDR, bus.DATA_TO_MEM);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", bus.DATA_ADDR, mon_e.addr);
                check("wr_data", bus.DATA_TO_MEM, mon_e.data);
                check("debug1", {31'd0, bus.DEBUG1}, 32'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input int b);
        bus.BUF_NUM = 2'(b);
        bus.TRIG_IN = 1'b1;
        tick();
        bus.TRIG_IN = 1'b0;
        if (m_en == 1) begin
            m_armed = 1; m_done = 0; m_buf = b; m_idx = 0;
        end
    endtask

    task automatic ctrl_write(input logic [31:0] v);
        bus.AXI_CONTROL = v;
        bus.AXI_CONTROL_WRITTEN = 1'b1;
        tick();
        bus.AXI_CONTROL_WRITTEN = 1'b0;
    endtask

    // Streams npairs (mode 1: lanes 1/0, mode 2: both 1, else random); model groups 16 pairs per word.
    task automatic stream(input int npairs, input int mode, input bit finish);
        logic [31:0] acc = 32'd0;
        int k = 0;
        int d1, d0;
        for (int i = 0; i < npairs; i++) begin
            if (mode == 1) begin d1 = 1; d0 = 0; end
            else if (mode == 2) begin d1 = 1; d0 = 1; end
            else begin d1 = int'($urandom % 2); d0 = int'($urandom % 2); end
            bus.SERIAL_DATA1_IN = d1[0];
            bus.SERIAL_DATA0_IN = d0[0];
            bus.ENABLE_XFR_IN = 1'b1;
            m_armed = 0;
            if (m_idx < WPB) begin
                acc = acc * 32'd4 + 32'(2 * d1 + d0);
                k++;
                if (k == 16) begin
                    exp_q.push_back('{addr: 32'(m_buf * WPB * 4 + m_idx * 4), data: acc});
                    n_pushed++;
                    m_idx++;
                    k = 0;
                    acc = 32'd0;
                end
            end
            tick();
        end
        if (finish) begin
            bus.ENABLE_XFR_IN = 1'b0;
            tick();
            m_armed = 0; m_done = 1;
        end
    endtask

    initial begin
        bus.SERIAL_DATA0_IN = 1'b0; bus.SERIAL_DATA1_IN = 1'b0; bus.ENABLE_XFR_IN = 1'b0;
        bus.BUF_NUM = 2'd0; bus.TRIG_IN = 1'b0;
        bus.AXI_CONTROL = 32'd0; bus.AXI_CONTROL_WRITTEN = 1'b0;
        tick(); tick();
        check("rst_status", bus.STATUS, 32'd0);
        check("rst_wr", {31'd0, bus.ENABLE_MEM_WRT}, 32'd0);
        check("rst_addr", bus.DATA_ADDR, 32'd0);
        check("rst_data", bus.DATA_TO_MEM, 32'd0);
        check("rst_debug2", {31'd0, bus.DEBUG2}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_status", bus.STATUS, 32'h0000_0040);

        arm(0); stream(32, 1, 1);
        check("two_words_status", bus.STATUS, exp_status(0));
        arm(2); stream(16, 2, 1);
        check("buf2_status", bus.STATUS, exp_status(0));
        arm(1); stream(10, 0, 1);
        check("partial_status", bus.STATUS, exp_status(0));
        for (int s = 0; s < 6; s++) begin
            arm(int'($urandom % 4));
            stream(int'($urandom_range(1, 80)), 0, 1);
            check("rand_status", bus.STATUS, exp_status(0));
            check("rand_debug2", {31'd0, bus.DEBUG2}, 32'd0);
        end
        arm(0); stream(1025 * 16, 0, 1);
        check("full_status", bus.STATUS, exp_status(0));

        arm(3);
        for (int i = 0; i < 5; i++) begin
            bus.SERIAL_DATA0_IN = 1'($urandom % 2);
            bus.SERIAL_DATA1_IN = 1'($urandom % 2);
            bus.ENABLE_XFR_IN = 1'b1;
            bus.TRIG_IN = (i == 2);
            tick();
        end
        bus.TRIG_IN = 1'b0;
        m_armed = 0; m_ovf = 1;
        check("ovf_status", bus.STATUS, exp_status(1));
        check("xfer_debug2", {31'd0, bus.DEBUG2}, 32'd1);
        ctrl_write(32'd1);
        bus.ENABLE_XFR_IN = 1'b0;
        m_ovf = 0; m_buf = 0; m_idx = 0; m_done = 0;
        check("clear_status", bus.STATUS, 32'h0000_0040);
        check("clear_debug2", {31'd0, bus.DEBUG2}, 32'd0);
        bus.TRIG_IN = 1'b1;
        ctrl_write(32'd1);
        bus.TRIG_IN = 1'b0;
        check("clear_beats_trig", bus.STATUS, 32'h0000_0040);
        tick();

        ctrl_write(32'd0); m_en = 0;
        check("disable_status", bus.STATUS, exp_status(0));
        arm(2); tick();
        check("disabled_trig", bus.STATUS, exp_status(0));
        ctrl_write(32'd2); m_en = 1;
        check("reenable_status", bus.STATUS, 32'h0000_0040);

        arm(1); stream(20, 0, 0);
        rst_n = 1'b0;
        tick();
        bus.ENABLE_XFR_IN = 1'b0;
        check("midrst_wr", {31'd0, bus.ENABLE_MEM_WRT}, 32'd0);
        check("midrst_status", bus.STATUS, 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_status", bus.STATUS, 32'h0000_0040);

        tick(); tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("write_count", 32'(n_seen), 32'(n_pushed));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
